// File: rtl/add_tree_pkg.sv
// Shared constant functions for the pipelined adder tree: depth, widths and
// the fixed-point reciprocal used by the optional mean output.
package add_tree_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned lvls_f(input int unsigned num_taps);
    return clog2(num_taps);
  endfunction

  function automatic int unsigned sum_w_f(input int unsigned data_w, input int unsigned num_taps);
    return data_w + clog2(num_taps);
  endfunction

  // Number of elements entering tree level lvl (ceil(num_taps / 2^lvl)).
  function automatic int unsigned level_n_f(input int unsigned num_taps, input int unsigned lvl);
    return (num_taps + (32'd1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int unsigned frac_f(input int unsigned sum_w);
    return sum_w + 8;
  endfunction

  function automatic longint unsigned recip_f(input int unsigned num_taps, input int unsigned frac);
    return ((64'd1 << frac) + 64'(num_taps / 2)) / 64'(num_taps);
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One adder-tree level: pairwise adds with 1-bit growth, odd element passed
// through zero-extended, everything registered under the shared advance enable.
module add_tree_level #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned IN_W = 8,
  localparam int unsigned N_OUT = (N_IN + 1) / 2,
  localparam int unsigned OUT_W = IN_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [N_OUT*OUT_W-1:0] out_data
);

  logic [N_OUT*OUT_W-1:0] nxt;

  always_comb begin
    nxt = '0;
    for (int unsigned i = 0; i < N_IN / 2; i++)
      nxt[i*OUT_W +: OUT_W] = {1'b0, in_data[2*i*IN_W +: IN_W]}
                            + {1'b0, in_data[(2*i+1)*IN_W +: IN_W]};
    if (N_IN % 2 == 1)
      nxt[(N_OUT-1)*OUT_W +: OUT_W] = {1'b0, in_data[(N_IN-1)*IN_W +: IN_W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= nxt;
    end
  end

endmodule

// File: rtl/add_tree_pipe.sv
// Fully pipelined NUM_TAPS-input adder tree with valid/ready backpressure.
// Define ADD_TREE_AVG_EN to add a registered rounded-mean stage and avg_out.
module add_tree_pipe
  import add_tree_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 9,
  parameter int unsigned DATA_W   = 8,
  localparam int unsigned LVLS  = lvls_f(NUM_TAPS),
  localparam int unsigned SUM_W = sum_w_f(DATA_W, NUM_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_TAPS*DATA_W-1:0] taps_in,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W-1:0]           sum_out,
  output logic                       out_last
`ifdef ADD_TREE_AVG_EN
  ,
  output logic [DATA_W-1:0]          avg_out
`endif
);

  logic             adv;
  logic             tree_valid;
  logic             tree_last;
  logic [SUM_W-1:0] tree_sum;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar j = 0; j < LVLS; j++) begin : g_lvl
    localparam int unsigned N_IN  = level_n_f(NUM_TAPS, j);
    localparam int unsigned IN_W  = DATA_W + j;
    localparam int unsigned N_OUT = level_n_f(NUM_TAPS, j + 1);

    logic [N_IN*IN_W-1:0]       d_in;
    logic                       v_in;
    logic                       l_in;
    logic [N_OUT*(IN_W+1)-1:0]  d_out;
    logic                       v_out;
    logic                       l_out;

    if (j == 0) begin : g_src
      assign d_in = taps_in;
      assign v_in = in_valid;
      assign l_in = in_last;
    end else begin : g_src
      assign d_in = g_lvl[j-1].d_out;
      assign v_in = g_lvl[j-1].v_out;
      assign l_in = g_lvl[j-1].l_out;
    end

    add_tree_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (v_in),
      .in_last   (l_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_last  (l_out),
      .out_data  (d_out)
    );
  end

  assign tree_sum   = g_lvl[LVLS-1].d_out;
  assign tree_valid = g_lvl[LVLS-1].v_out;
  assign tree_last  = g_lvl[LVLS-1].l_out;

`ifdef ADD_TREE_AVG_EN
  localparam int unsigned       FRAC   = frac_f(SUM_W);
  localparam longint unsigned   RECIP  = recip_f(NUM_TAPS, FRAC);
  localparam int unsigned       PROD_W = SUM_W + FRAC + 1;

  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] avg_nxt;

  // Reciprocal multiply with half-LSB rounding replaces a divider.
  always_comb begin
    prod    = PROD_W'(tree_sum) * PROD_W'(RECIP) + (PROD_W'(1) << (FRAC - 1));
    avg_nxt = DATA_W'(prod >> FRAC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sum_out   <= '0;
      avg_out   <= '0;
    end else if (adv) begin
      out_valid <= tree_valid;
      out_last  <= tree_last;
      sum_out   <= tree_sum;
      avg_out   <= avg_nxt;
    end
  end
`else
  assign out_valid = tree_valid;
  assign out_last  = tree_last;
  assign sum_out   = tree_sum;
`endif

endmodule
